// File: rtl/resample_pkg.sv
// Shared types, rate codes and bank mapping for the
// resampler rate-change controller.
package resample_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    SWITCH,
    SETTLE
  } state_t;

  localparam logic [2:0] RATE_1536K = 3'd0;
  localparam logic [2:0] RATE_768K  = 3'd1;
  localparam logic [2:0] RATE_384K  = 3'd2;
  localparam logic [2:0] RATE_192K  = 3'd3;
  localparam logic [2:0] RATE_96K   = 3'd4;
  localparam logic [2:0] RATE_48K   = 3'd5;
  localparam logic [2:0] RATE_24K   = 3'd6;
  localparam logic [2:0] RATE_12K   = 3'd7;

  localparam int NUM_BANKS = 5;

  // Slow rates share the last bank.
  function automatic int unsigned bank(
    input int unsigned r,
    input int unsigned nb
  );
    return (r < nb) ? r : nb - 1;
  endfunction

endpackage

// File: rtl/resample_rate_ctrl_if.sv
// Rate-request handshake between host control and the
// rate-change controller.
interface resample_rate_ctrl_if #(
  parameter int RATE_BITS = 3
);

  logic [RATE_BITS-1:0] req_rate;
  logic                 req_valid;
  logic                 req_ready;

  modport master (
    output req_rate,
    output req_valid,
    input  req_ready
  );

  modport slave (
    input  req_rate,
    input  req_valid,
    output req_ready
  );

endinterface

// File: rtl/resample_rate_ctrl_counter.sv
// Loadable sample-tick down-counter shared by the flush
// and settle phases.
module sample_tick_counter #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CNT_BITS-1:0] value,
  input  logic                tick,
  output logic                zero_next
);

  logic [CNT_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_next = tick && !load &&
                     (cnt == CNT_BITS'(1));

endmodule

// File: rtl/resample_rate_ctrl.sv
// Sequences sample-rate changes: mute and flush, switch
// coefficient bank on a sample boundary, settle, unmute.
module resample_rate_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int RATE_BITS      = 3,
  parameter int NUM_BANKS      = resample_pkg::NUM_BANKS,
  parameter int RESET_RATE     = 5,
  parameter int FLUSH_SAMPLES  = 64,
  parameter int SETTLE_SAMPLES = 64,
  parameter int CNT_BITS       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic [DATA_WIDTH-1:0] data_in,
  resample_rate_ctrl_if.slave   req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [RATE_BITS-1:0]  active_rate,
  output logic [RATE_BITS-1:0]  coeff_sel,
  output logic                  filter_clear,
  output logic                  busy,
  output logic                  change_done
);

  import resample_pkg::*;

  localparam logic [RATE_BITS-1:0] RST_RATE =
    RATE_BITS'(RESET_RATE);
  localparam logic [RATE_BITS-1:0] RST_BANK =
    RATE_BITS'(bank(RESET_RATE, NUM_BANKS));

  state_t               state;
  logic [RATE_BITS-1:0] pending;
  logic                 change;
  logic                 cnt_load;
  logic                 cnt_tick;
  logic                 cnt_zero;
  logic [CNT_BITS-1:0]  cnt_value;

  assign req.req_ready = (state == RUN);

  assign change = (state == RUN) && req.req_valid &&
                  (req.req_rate != active_rate);

  assign cnt_load  = change || (state == SWITCH);
  assign cnt_value = (state == RUN) ?
                     CNT_BITS'(FLUSH_SAMPLES) :
                     CNT_BITS'(SETTLE_SAMPLES);
  assign cnt_tick  = sample_tick &&
                     (state == FLUSH || state == SETTLE);

  sample_tick_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .value     (cnt_value),
    .tick      (cnt_tick),
    .zero_next (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pending      <= RST_RATE;
      active_rate  <= RST_RATE;
      coeff_sel    <= RST_BANK;
      data_out     <= '0;
      filter_clear <= 1'b0;
      busy         <= 1'b0;
      change_done  <= 1'b0;
    end else begin
      filter_clear <= 1'b0;
      change_done  <= 1'b0;
      unique case (state)
        RUN: begin
          if (sample_tick) data_out <= data_in;
          if (change) begin
            pending <= req.req_rate;
            state   <= FLUSH;
            busy    <= 1'b1;
          end
        end
        FLUSH: begin
          if (sample_tick) data_out <= '0;
          // Bank and rate flip together so the filter never
          // sees taps from two banks.
          if (cnt_zero) begin
            state        <= SWITCH;
            active_rate  <= pending;
            coeff_sel    <= RATE_BITS'(
                              bank(32'(pending), NUM_BANKS));
            filter_clear <= 1'b1;
          end
        end
        SWITCH: begin
          if (sample_tick) data_out <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (sample_tick) data_out <= '0;
          if (cnt_zero) begin
            state       <= RUN;
            busy        <= 1'b0;
            change_done <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resample_rate_ctrl.sv
// Vector table, directed corner sequences and random
// traffic checked against a phase-level reference model.
module tb_resample_rate_ctrl;

  localparam int FL = 4;
  localparam int ST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] data_out;
  logic [2:0]  active_rate;
  logic [2:0]  coeff_sel;
  logic        filter_clear;
  logic        busy;
  logic        change_done;

  int errors = 0;
  int checks = 0;

  resample_rate_ctrl_if #(.RATE_BITS(3)) rif ();

  resample_rate_ctrl #(
    .DATA_WIDTH     (32),
    .RATE_BITS      (3),
    .NUM_BANKS      (5),
    .RESET_RATE     (5),
    .FLUSH_SAMPLES  (FL),
    .SETTLE_SAMPLES (ST),
    .CNT_BITS       (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (tick),
    .data_in      (din),
    .req          (rif.slave),
    .data_out     (data_out),
    .active_rate  (active_rate),
    .coeff_sel    (coeff_sel),
    .filter_clear (filter_clear),
    .busy         (busy),
    .change_done  (change_done)
  );

  always #5 clk = ~clk;

  // Reference model: counts of zero samples still owed.
  logic [31:0] m_data;
  logic [2:0]  m_rate;
  logic [2:0]  m_pend;
  int          m_flush_left;
  bit          m_switch;
  int          m_settle_left;
  bit          m_clear;
  bit          m_done;

  function automatic bit m_busy();
    return m_flush_left > 0 || m_switch || m_settle_left > 0;
  endfunction

  function automatic logic [2:0] m_bank(logic [2:0] r);
    return (r < 3'd5) ? r : 3'd4;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_clear = 1'b0;
    m_done  = 1'b0;
    if (rst) begin
      m_data = '0; m_rate = 3'd5; m_pend = 3'd5;
      m_flush_left = 0; m_switch = 0; m_settle_left = 0;
    end else if (!m_busy()) begin
      if (tick) m_data = din;
      if (rif.req_valid && rif.req_rate != m_rate) begin
        m_pend = rif.req_rate;
        m_flush_left = FL;
      end
    end else if (m_flush_left > 0) begin
      if (tick) begin
        m_data = '0;
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_switch = 1;
          m_rate = m_pend;
          m_clear = 1'b1;
        end
      end
    end else if (m_switch) begin
      if (tick) m_data = '0;
      m_switch = 0;
      m_settle_left = ST;
    end else begin
      if (tick) begin
        m_data = '0;
        m_settle_left--;
        if (m_settle_left == 0) m_done = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("data_out", data_out, m_data);
    chk("active_rate", 32'(active_rate), 32'(m_rate));
    chk("coeff_sel", 32'(coeff_sel), 32'(m_bank(m_rate)));
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("req_ready", 32'(rif.req_ready), 32'(!m_busy()));
    chk("filter_clear", 32'(filter_clear), 32'(m_clear));
    chk("change_done", 32'(change_done), 32'(m_done));
  endtask

  typedef struct {
    logic        tk;
    logic [31:0] d;
    logic        v;
    logic [2:0]  r;
    logic [31:0] ed;
    logic        eb;
    logic        ec;
    logic        edn;
    logic [2:0]  er;
    logic [2:0]  ecs;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit ok;
    rif.req_valid = 1'b0;
    rif.req_rate  = 3'd0;

    tbl[0]  = '{1, 32'h1234ABCD, 0, 0, 32'h1234ABCD, 0, 0, 0, 5, 4};
    tbl[1]  = '{0, 32'hDEAD0001, 1, 5, 32'h1234ABCD, 0, 0, 0, 5, 4};
    tbl[2]  = '{1, 32'h11112222, 1, 2, 32'h11112222, 1, 0, 0, 5, 4};
    tbl[3]  = '{1, 32'hDEAD0003, 0, 0, 32'h0, 1, 0, 0, 5, 4};
    tbl[4]  = '{0, 32'hDEAD0004, 0, 0, 32'h0, 1, 0, 0, 5, 4};
    tbl[5]  = '{1, 32'hDEAD0005, 0, 0, 32'h0, 1, 0, 0, 5, 4};
    tbl[6]  = '{1, 32'hDEAD0006, 0, 0, 32'h0, 1, 0, 0, 5, 4};
    tbl[7]  = '{1, 32'hDEAD0007, 0, 0, 32'h0, 1, 1, 0, 2, 2};
    tbl[8]  = '{1, 32'hDEAD0008, 0, 0, 32'h0, 1, 0, 0, 2, 2};
    tbl[9]  = '{1, 32'hDEAD0009, 0, 0, 32'h0, 1, 0, 0, 2, 2};
    tbl[10] = '{1, 32'h00005555, 0, 0, 32'h0, 0, 0, 1, 2, 2};
    tbl[11] = '{1, 32'h00006666, 0, 0, 32'h6666, 0, 0, 0, 2, 2};

    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_rate", 32'(active_rate), 32'd5);
    chk("rst_coeff", 32'(coeff_sel), 32'd4);
    chk("rst_ready", 32'(rif.req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", data_out, 32'd0);

    for (int i = 0; i < 12; i++) begin
      tick          = tbl[i].tk;
      din           = tbl[i].d;
      rif.req_valid = tbl[i].v;
      rif.req_rate  = tbl[i].r;
      cyc();
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
      chk($sformatf("tbl%0d_busy", i), 32'(busy),
          32'(tbl[i].eb));
      chk($sformatf("tbl%0d_clear", i), 32'(filter_clear),
          32'(tbl[i].ec));
      chk($sformatf("tbl%0d_done", i), 32'(change_done),
          32'(tbl[i].edn));
      chk($sformatf("tbl%0d_rate", i), 32'(active_rate),
          32'(tbl[i].er));
      chk($sformatf("tbl%0d_coeff", i), 32'(coeff_sel),
          32'(tbl[i].ecs));
    end
    tick = 1'b0;
    rif.req_valid = 1'b0;

    // Rate 7 held while busy, accepted only once back in RUN.
    rst = 1'b1; cyc(); rst = 1'b0;
    tick = 1'b1; din = 32'hA5A5_0001;
    rif.req_valid = 1'b1; rif.req_rate = 3'd1;
    cyc();
    rif.req_rate = 3'd7;
    cyc();
    cyc();
    chk("hold_ready_mid_flush", 32'(rif.req_ready), 32'd0);
    chk("hold_rate_mid_flush", 32'(active_rate), 32'd5);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      din = $urandom;
      cyc();
      if (active_rate == 3'd7) ok = 1;
    end
    chk("hold_timeout", 32'(ok), 32'd1);
    chk("hold_rate7", 32'(active_rate), 32'd7);
    chk("hold_coeff7", 32'(coeff_sel), 32'd4);
    rif.req_valid = 1'b0;
    repeat (12) cyc();
    chk("hold_final_busy", 32'(busy), 32'd0);

    // Reset in the middle of a flush drops the pending rate.
    rst = 1'b1; cyc(); rst = 1'b0;
    tick = 1'b0; rif.req_valid = 1'b1; rif.req_rate = 3'd1;
    cyc();
    rif.req_valid = 1'b0; tick = 1'b1;
    repeat (2) cyc();
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rate", 32'(active_rate), 32'd5);
    chk("mid_rst_data", data_out, 32'd0);
    chk("mid_rst_coeff", 32'(coeff_sel), 32'd4);
    repeat (10) begin din = $urandom; cyc(); end
    chk("mid_rst_rate_after", 32'(active_rate), 32'd5);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      tick          = ($urandom_range(0, 2) != 0);
      din           = $urandom;
      rif.req_valid = ($urandom_range(0, 5) == 0);
      rif.req_rate  = 3'($urandom_range(0, 7));
      rst           = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
